rr_index_arbiter: RTL and testbench
===================================

// Module: rr_index_arbiter
//
// PURPOSE
// Round-robin arbiter that sits directly upstream of the one-hot decoder.
// Each cycle it scans an OUT-wide request vector and picks one requester.
// It presents that requester's binary index on N, and the decoder turns N back into a one-hot grant.
// Output is registered and uses a valid/ready handshake.
// Rotating priority guarantees no requester starves while it keeps req asserted.
//
// PARAMETERS
// N_IN  3          width of the binary index N (matches decoder N_IN)
// OUT   2**N_IN    number of requesters / width of req (matches decoder OUT)
//
// PORTS
// clk        in   1     single clock, all state updates on posedge
// rst        in   1     synchronous reset, active-high
// req        in   OUT   request vector, bit i = requester i wants service
// out_ready  in   1     downstream accepts N this cycle
// out_valid  out  1     N holds a granted index
// N          out  N_IN  binary index of granted requester (to decoder .N)
//
// BEHAVIOUR
// - Reset (rst=1 at posedge): out_valid=0, N=0, priority pointer ptr=0, state=IDLE.
//   rst overrides everything, including a pending handshake; no grant survives.
// - State: IDLE (out_valid=0), HOLD (out_valid=1). Outputs are pure registers.
// - Search: first set bit of req at index ptr, ptr+1, ... OUT-1, 0, ... ptr-1 (circular).
//   Search uses the pointer value that applies for this cycle (ptr_nxt, see below).
// - IDLE: if |req, then at next edge N<=found index, out_valid<=1, go HOLD; else stay IDLE.
//   Latency req->out_valid = 1 cycle.
// - HOLD, out_ready=0: N and out_valid held stable. Grant is sticky even if req drops
//   or higher-priority req appears.
// - HOLD, out_ready=1 (handshake): ptr<=N+1 mod OUT (natural N_IN-bit wrap, 7->0 for N_IN=3).
//   In the same cycle, search req with ptr_nxt=N+1.
//   If a bit is found: N<=found index, stay HOLD (back-to-back grants, no bubble).
//   If none: out_valid<=0, go IDLE; N keeps last value.
// - Just-granted requester has lowest priority after handshake; it is re-granted only if it is the sole requester.
// - ptr changes only on handshake or reset.
// - req is sampled only when a new grant is being chosen; no other req effect.
// - out_ready while IDLE is ignored.
// - OUT must equal 2**N_IN. No X on outputs after first reset edge.
//
// TESTING (N_IN=3, OUT=8, all checks one cycle after the driving edge)
// 1 rst=1 two cycles, req=8'hFF -> out_valid=0, N=0 throughout; release rst -> N=0, out_valid=1 next cycle.
// 2 req=8'b0001_0000, out_ready=1 held -> out_valid=1, N=4 every cycle (sole requester re-granted).
// 3 reset, req=8'b1000_0001, out_ready=1 -> N sequence 0,7,0,7 with out_valid=1 continuously.
// 4 reset, req=8'b0000_0110, out_ready=0 for 3 cycles -> N=1 held; drop req to 0, still N=1, out_valid=1;
//   out_ready=1 one cycle -> out_valid=0 next cycle, N stays 1.
// 5 reset, req=8'hFF, out_ready=1 for 10 cycles -> N=0,1,2,3,4,5,6,7,0,1 (pointer wrap).
// 6 mid-op: in HOLD with N=5, assert rst one cycle -> out_valid=0, N=0;
//   then req=8'b0010_0001 -> N=0 (ptr was reset to 0).

Source files
------------

// File: rtl/rr_index_arbiter.sv
// Round-robin arbiter presenting the granted requester as a binary index.
// Registered output, valid/ready handshake, rotating priority pointer.
module rr_index_arbiter #(
  parameter int N_IN = 3,
  parameter int OUT  = 2**N_IN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OUT-1:0]  req,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [N_IN-1:0] N
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t          state, state_d;
  logic [N_IN-1:0] ptr, ptr_d;
  logic [N_IN-1:0] ptr_nxt;
  logic [N_IN-1:0] n_d;
  logic [N_IN-1:0] idx;
  logic [N_IN-1:0] pick;
  logic            found;
  logic            hs;

  assign hs      = (state == HOLD) && out_ready;
  assign ptr_nxt = hs ? N + N_IN'(1) : ptr;

  // Circular scan starting at the pointer that applies this cycle.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 0; k < OUT; k++) begin
      idx = ptr_nxt + N_IN'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_d = state;
    n_d     = N;
    ptr_d   = ptr;
    unique case (state)
      IDLE: begin
        if (found) begin
          n_d     = pick;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          ptr_d = ptr_nxt;
          if (found) begin
            n_d = pick;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      N     <= '0;
      ptr   <= '0;
    end else begin
      state <= state_d;
      N     <= n_d;
      ptr   <= ptr_d;
    end
  end

  assign out_valid = (state == HOLD);

endmodule

// File: tb/tb_rr_index_arbiter.sv
// Scoreboard bench for rr_index_arbiter: directed scenarios plus random
// traffic checked against a circular-search reference model.
module tb_rr_index_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       out_ready;
  logic       out_valid;
  logic [2:0] N;

  rr_index_arbiter #(.N_IN(3), .OUT(8)) dut (
    .clk(clk), .rst(rst), .req(req),
    .out_ready(out_ready), .out_valid(out_valid), .N(N)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v;
    int n;
    int dv;
    int dn;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_chk = 0;
  int   n_fail = 0;

  bit m_v = 0;
  int m_n = 0;
  int m_p = 0;

  function automatic int search(logic [7:0] r, int p);
    for (int k = 0; k < 8; k++)
      if (r[(p + k) % 8]) return (p + k) % 8;
    return -1;
  endfunction

  task automatic step(input bit r, input logic [7:0] q, input bit rdy,
                      input int dv, input int dn);
    int f;
    exp_t x;
    rst = r; req = q; out_ready = rdy;
    if (r) begin
      m_v = 0; m_n = 0; m_p = 0;
    end else if (!m_v) begin
      f = search(q, m_p);
      if (f >= 0) begin m_n = f; m_v = 1; end
    end else if (rdy) begin
      m_p = (m_n + 1) % 8;
      f = search(q, m_p);
      if (f >= 0) m_n = f;
      else m_v = 0;
    end
    x.v = m_v; x.n = m_n; x.dv = dv; x.dn = dn;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_chk++;
      if (out_valid !== e.v) begin
        n_fail++;
        $display("FAIL valid t=%0t got %b want %b", $time, out_valid, e.v);
      end
      n_chk++;
      if (N !== 3'(e.n)) begin
        n_fail++;
        $display("FAIL index t=%0t got %0d want %0d", $time, N, e.n);
      end
      if (e.dv >= 0) begin
        n_chk++;
        if (out_valid !== e.dv[0]) begin
          n_fail++;
          $display("FAIL dir_valid t=%0t got %b want %0d",
                   $time, out_valid, e.dv);
        end
      end
      if (e.dn >= 0) begin
        n_chk++;
        if (N !== 3'(e.dn)) begin
          n_fail++;
          $display("FAIL dir_index t=%0t got %0d want %0d", $time, N, e.dn);
        end
      end
    end
  end

  initial begin
    int seq5[10];
    seq5 = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};

    step(1, 8'hFF, 0, 0, 0);
    step(1, 8'hFF, 0, 0, 0);
    step(0, 8'hFF, 0, 1, 0);

    for (int i = 0; i < 4; i++) step(0, 8'b0001_0000, 1, 1, 4);

    step(1, 8'h00, 0, 0, 0);
    step(0, 8'b1000_0001, 1, 1, 0);
    step(0, 8'b1000_0001, 1, 1, 7);
    step(0, 8'b1000_0001, 1, 1, 0);
    step(0, 8'b1000_0001, 1, 1, 7);

    step(1, 8'h00, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 8'b0000_0110, 0, 1, 1);
    step(0, 8'h00, 0, 1, 1);
    step(0, 8'h00, 1, 0, 1);
    step(0, 8'h00, 0, 0, 1);

    step(1, 8'h00, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 8'hFF, 1, 1, seq5[i]);

    step(1, 8'h00, 0, 0, 0);
    step(0, 8'b0010_0000, 0, 1, 5);
    step(0, 8'b0010_0000, 0, 1, 5);
    step(1, 8'b0010_0000, 1, 0, 0);
    step(0, 8'b0010_0001, 0, 1, 0);

    for (int i = 0; i < 400; i++) begin
      logic [7:0] q;
      q = 8'($urandom) & 8'($urandom);
      if ($urandom_range(0, 3) == 0) q = 8'h00;
      step($urandom_range(0, 40) == 0, q, $urandom_range(0, 2) != 0, -1, -1);
    end

    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
